// File: rtl/amm_rd_wr_arbiter_pkg.sv
// Shared types for the Avalon-MM read/write arbiter: arbitration state and grant owner.
package amm_rd_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOCK_RD,
    LOCK_WR
  } arb_state_t;

  typedef enum logic {
    GNT_RD,
    GNT_WR
  } grant_t;

endpackage

// File: rtl/amm_rd_wr_arbiter_pending_cnt.sv
// Saturating up/down counter of accepted reads still awaiting readdatavalid.
module amm_rd_wr_arbiter_pending_cnt #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Simultaneous inc/dec cancel; a decrement at zero is absorbed.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q >= CNT_W'(LIMIT));

  underflow_a : assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                 !(dec_i && !inc_i && (cnt_q == '0)));

endmodule

// File: rtl/amm_rd_wr_arbiter.sv
// Merges a read master and a write master onto one Avalon-MM slave: round-robin
// arbitration, grant held across slave stalls, outstanding reads capped.
module amm_rd_wr_arbiter
  import amm_rd_wr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 10,
  parameter int BYTE_CNT       = DATA_WIDTH / 8,
  parameter int MAX_PENDING_RD = 4,
  parameter int CNT_W          = $clog2(MAX_PENDING_RD + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH-1:0] rd_address_i,
  input  logic                  rd_read_i,
  output logic [DATA_WIDTH-1:0] rd_readdata_o,
  output logic                  rd_readdatavalid_o,
  output logic                  rd_waitrequest_o,
  input  logic [ADDR_WIDTH-1:0] wr_address_i,
  input  logic                  wr_write_i,
  input  logic [DATA_WIDTH-1:0] wr_writedata_i,
  input  logic [BYTE_CNT-1:0]   wr_byteenable_i,
  output logic                  wr_waitrequest_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [DATA_WIDTH-1:0] mem_writedata_o,
  output logic [BYTE_CNT-1:0]   mem_byteenable_o,
  input  logic [DATA_WIDTH-1:0] mem_readdata_i,
  input  logic                  mem_readdatavalid_i,
  input  logic                  mem_waitrequest_i,
  output logic [CNT_W-1:0]      pending_rd_o
);

  arb_state_t state_q, state_d;
  grant_t     last_q, last_d;

  logic rd_full;
  logic rd_elig;
  logic gnt_rd, gnt_wr;
  logic rd_acc, wr_acc;

  assign rd_elig = rd_read_i && !rd_full;

  // Zero-latency winner in IDLE; a locked state pins the grant regardless of the pending cap.
  always_comb begin
    gnt_rd = 1'b0;
    gnt_wr = 1'b0;
    unique case (state_q)
      LOCK_RD: gnt_rd = 1'b1;
      LOCK_WR: gnt_wr = 1'b1;
      default: begin
        if (rd_elig && wr_write_i) begin
          if (last_q == GNT_WR) gnt_rd = 1'b1;
          else                  gnt_wr = 1'b1;
        end else if (rd_elig) begin
          gnt_rd = 1'b1;
        end else if (wr_write_i) begin
          gnt_wr = 1'b1;
        end
      end
    endcase
  end

  assign mem_read_o       = rst_n_i && gnt_rd && rd_read_i;
  assign mem_write_o      = rst_n_i && gnt_wr && wr_write_i;
  assign mem_address_o    = gnt_rd ? rd_address_i : wr_address_i;
  assign mem_writedata_o  = wr_writedata_i;
  assign mem_byteenable_o = wr_byteenable_i;

  always_comb begin
    rd_waitrequest_o = mem_waitrequest_i;
    wr_waitrequest_o = mem_waitrequest_i;
    if (!rst_n_i) begin
      rd_waitrequest_o = 1'b1;
      wr_waitrequest_o = 1'b1;
    end else if (gnt_wr) begin
      rd_waitrequest_o = 1'b1;
    end else if (gnt_rd) begin
      wr_waitrequest_o = 1'b1;
    end else if (rd_read_i) begin
      rd_waitrequest_o = 1'b1;
    end
  end

  assign rd_readdata_o      = mem_readdata_i;
  assign rd_readdatavalid_o = rst_n_i && mem_readdatavalid_i;

  assign rd_acc = mem_read_o && !mem_waitrequest_i;
  assign wr_acc = mem_write_o && !mem_waitrequest_i;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      LOCK_RD: begin
        if (!rd_read_i) begin
          state_d = IDLE;
        end else if (rd_acc) begin
          state_d = IDLE;
          last_d  = GNT_RD;
        end
      end
      LOCK_WR: begin
        if (!wr_write_i) begin
          state_d = IDLE;
        end else if (wr_acc) begin
          state_d = IDLE;
          last_d  = GNT_WR;
        end
      end
      default: begin
        if (rd_acc)           last_d  = GNT_RD;
        else if (wr_acc)      last_d  = GNT_WR;
        else if (mem_read_o)  state_d = LOCK_RD;
        else if (mem_write_o) state_d = LOCK_WR;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      last_q  <= GNT_WR;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  amm_rd_wr_arbiter_pending_cnt #(
    .LIMIT (MAX_PENDING_RD),
    .CNT_W (CNT_W)
  ) u_pending_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (rd_acc),
    .dec_i   (mem_readdatavalid_i),
    .cnt_o   (pending_rd_o),
    .full_o  (rd_full)
  );

endmodule

// File: tb/tb_amm_rd_wr_arbiter.sv
// Bench for amm_rd_wr_arbiter: directed scenarios with literal expectations, then
// random traffic compared every cycle against a transaction-level arbitration model.
module tb_amm_rd_wr_arbiter;

  localparam int DW   = 64;
  localparam int AW   = 10;
  localparam int BC   = DW / 8;
  localparam int MAXP = 4;
  localparam int CW   = $clog2(MAXP + 1);

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [AW-1:0] rd_address_i;
  logic          rd_read_i;
  logic [DW-1:0] rd_readdata_o;
  logic          rd_readdatavalid_o;
  logic          rd_waitrequest_o;
  logic [AW-1:0] wr_address_i;
  logic          wr_write_i;
  logic [DW-1:0] wr_writedata_i;
  logic [BC-1:0] wr_byteenable_i;
  logic          wr_waitrequest_o;
  logic [AW-1:0] mem_address_o;
  logic          mem_read_o;
  logic          mem_write_o;
  logic [DW-1:0] mem_writedata_o;
  logic [BC-1:0] mem_byteenable_o;
  logic [DW-1:0] mem_readdata_i;
  logic          mem_readdatavalid_i;
  logic          mem_waitrequest_i;
  logic [CW-1:0] pending_rd_o;

  amm_rd_wr_arbiter #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .BYTE_CNT       (BC),
    .MAX_PENDING_RD (MAXP)
  ) dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .rd_address_i        (rd_address_i),
    .rd_read_i           (rd_read_i),
    .rd_readdata_o       (rd_readdata_o),
    .rd_readdatavalid_o  (rd_readdatavalid_o),
    .rd_waitrequest_o    (rd_waitrequest_o),
    .wr_address_i        (wr_address_i),
    .wr_write_i          (wr_write_i),
    .wr_writedata_i      (wr_writedata_i),
    .wr_byteenable_i     (wr_byteenable_i),
    .wr_waitrequest_o    (wr_waitrequest_o),
    .mem_address_o       (mem_address_o),
    .mem_read_o          (mem_read_o),
    .mem_write_o         (mem_write_o),
    .mem_writedata_o     (mem_writedata_o),
    .mem_byteenable_o    (mem_byteenable_o),
    .mem_readdata_i      (mem_readdata_i),
    .mem_readdatavalid_i (mem_readdatavalid_i),
    .mem_waitrequest_i   (mem_waitrequest_i),
    .pending_rd_o        (pending_rd_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner = requester holding the bus through a stall (0 none, 1 rd, 2 wr),
  // last = most recently accepted requester, pend = reads accepted minus responses.
  int m_owner, m_last, m_pend, w;
  bit m_rd_acc, m_wr_acc, rd_ok, e_read, e_write, e_rdw, e_wrw;
  logic [AW-1:0] e_addr;

  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      chk1("rst_mem_read", mem_read_o, 1'b0);
      chk1("rst_mem_write", mem_write_o, 1'b0);
      chk1("rst_rd_wait", rd_waitrequest_o, 1'b1);
      chk1("rst_wr_wait", wr_waitrequest_o, 1'b1);
      chk1("rst_rdv", rd_readdatavalid_o, 1'b0);
      chk64("rst_pending", 64'(pending_rd_o), 64'd0);
      m_owner  = 0;
      m_last   = 2;
      m_pend   = 0;
      m_rd_acc = 1'b0;
      m_wr_acc = 1'b0;
    end else begin
      rd_ok = rd_read_i && (m_pend < MAXP);
      if (m_owner != 0)              w = m_owner;
      else if (rd_ok && wr_write_i)  w = (m_last == 1) ? 2 : 1;
      else if (rd_ok)                w = 1;
      else if (wr_write_i)           w = 2;
      else                           w = 0;
      e_read  = (w == 1) && rd_read_i;
      e_write = (w == 2) && wr_write_i;
      e_addr  = (w == 1) ? rd_address_i : wr_address_i;
      e_rdw   = (w == 2) ? 1'b1 : (w == 1) ? mem_waitrequest_i : (rd_read_i ? 1'b1 : mem_waitrequest_i);
      e_wrw   = (w == 1) ? 1'b1 : mem_waitrequest_i;

      chk1("mem_read", mem_read_o, e_read);
      chk1("mem_write", mem_write_o, e_write);
      chk64("mem_address", 64'(mem_address_o), 64'(e_addr));
      chk64("mem_writedata", mem_writedata_o, wr_writedata_i);
      chk64("mem_byteenable", 64'(mem_byteenable_o), 64'(wr_byteenable_i));
      chk1("rd_wait", rd_waitrequest_o, e_rdw);
      chk1("wr_wait", wr_waitrequest_o, e_wrw);
      chk1("rd_rdv", rd_readdatavalid_o, mem_readdatavalid_i);
      chk64("rd_readdata", rd_readdata_o, mem_readdata_i);
      chk64("pending", 64'(pending_rd_o), 64'(m_pend));

      if (w != 0) begin
        if (!(e_read || e_write)) begin
          m_owner = 0;
        end else if (mem_waitrequest_i) begin
          m_owner = w;
        end else begin
          m_owner = 0;
          m_last  = w;
        end
      end
      m_rd_acc = e_read && !mem_waitrequest_i;
      m_wr_acc = e_write && !mem_waitrequest_i;
      m_pend   = m_pend + int'(m_rd_acc) - int'(mem_readdatavalid_i);
      if (m_pend < 0) m_pend = 0;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    rd_read_i           = 1'b0;
    wr_write_i          = 1'b0;
    mem_waitrequest_i   = 1'b0;
    mem_readdatavalid_i = 1'b0;
  endtask

  initial begin
    rst_n_i         = 1'b0;
    rd_address_i    = '0;
    wr_address_i    = '0;
    wr_writedata_i  = '0;
    wr_byteenable_i = '0;
    mem_readdata_i  = '0;
    idle_in();
    rd_read_i           = 1'b1;
    wr_write_i          = 1'b1;
    mem_readdatavalid_i = 1'b1;
    #2;
    chk1("reset_mem_read", mem_read_o, 1'b0);
    chk1("reset_rd_wait", rd_waitrequest_o, 1'b1);
    chk1("reset_wr_wait", wr_waitrequest_o, 1'b1);
    chk1("reset_rdv", rd_readdatavalid_o, 1'b0);
    tick();
    tick();
    idle_in();
    rst_n_i = 1'b1;

    // Lone read, response forwarded
    tick();
    rd_read_i = 1'b1; rd_address_i = 10'h010;
    #1;
    chk1("lone_rd_read", mem_read_o, 1'b1);
    chk64("lone_rd_addr", 64'(mem_address_o), 64'h010);
    chk64("lone_rd_pend0", 64'(pending_rd_o), 64'd0);
    tick();
    rd_read_i = 1'b0; mem_readdatavalid_i = 1'b1; mem_readdata_i = 64'h0123_4567_89AB_CDEF;
    #1;
    chk64("lone_rd_pend1", 64'(pending_rd_o), 64'd1);
    chk64("lone_rd_data", rd_readdata_o, 64'h0123_4567_89AB_CDEF);
    chk1("lone_rd_rdv", rd_readdatavalid_o, 1'b1);
    tick();
    mem_readdatavalid_i = 1'b0;
    #1;
    chk64("lone_rd_pend_back", 64'(pending_rd_o), 64'd0);

    // Lone write
    tick();
    wr_write_i = 1'b1; wr_address_i = 10'h020; wr_writedata_i = 64'hFF; wr_byteenable_i = 8'h01;
    #1;
    chk1("lone_wr_write", mem_write_o, 1'b1);
    chk1("lone_wr_read", mem_read_o, 1'b0);
    chk64("lone_wr_addr", 64'(mem_address_o), 64'h020);
    chk64("lone_wr_data", mem_writedata_o, 64'hFF);
    chk64("lone_wr_be", 64'(mem_byteenable_o), 64'h01);
    tick();
    wr_write_i = 1'b0;
    #1;
    chk1("lone_wr_done", mem_write_o, 1'b0);
    chk64("lone_wr_pend", 64'(pending_rd_o), 64'd0);

    // Continuous contention alternates starting with read
    for (int k = 0; k < 8; k++) begin
      tick();
      rd_read_i = 1'b1; rd_address_i = AW'(k);
      wr_write_i = 1'b1; wr_address_i = AW'(k + 'h100);
      mem_readdatavalid_i = (k % 2 == 1);
      #1;
      chk1("rr_read", mem_read_o, (k % 2 == 0));
      chk1("rr_write", mem_write_o, (k % 2 == 1));
      chk1("rr_rd_wait", rd_waitrequest_o, (k % 2 == 1));
      chk1("rr_wr_wait", wr_waitrequest_o, (k % 2 == 0));
    end
    tick();
    idle_in();
    #1;
    chk64("rr_pend", 64'(pending_rd_o), 64'd0);

    // Write wins after a read, stalls 3 cycles, read follows acceptance
    tick();
    rd_read_i = 1'b1; rd_address_i = 10'h030;
    #1;
    chk1("lk_pre_read", mem_read_o, 1'b1);
    tick();
    rd_address_i = 10'h031;
    wr_write_i = 1'b1; wr_address_i = 10'h040; wr_writedata_i = 64'hAAAA_5555_0000_FFFF; wr_byteenable_i = 8'hFF;
    mem_waitrequest_i = 1'b1; mem_readdatavalid_i = 1'b1;
    #1;
    chk1("lk_write0", mem_write_o, 1'b1);
    chk1("lk_read0", mem_read_o, 1'b0);
    chk1("lk_rd_wait0", rd_waitrequest_o, 1'b1);
    chk1("lk_wr_wait0", wr_waitrequest_o, 1'b1);
    for (int j = 0; j < 2; j++) begin
      tick();
      mem_readdatavalid_i = 1'b0;
      #1;
      chk1("lk_write_hold", mem_write_o, 1'b1);
      chk1("lk_rd_wait_hold", rd_waitrequest_o, 1'b1);
      chk64("lk_addr_hold", 64'(mem_address_o), 64'h040);
    end
    tick();
    mem_waitrequest_i = 1'b0;
    #1;
    chk1("lk_write_acc", mem_write_o, 1'b1);
    chk1("lk_wr_wait_acc", wr_waitrequest_o, 1'b0);
    chk1("lk_rd_wait_acc", rd_waitrequest_o, 1'b1);
    tick();
    wr_address_i = 10'h041;
    #1;
    chk1("lk_next_read", mem_read_o, 1'b1);
    chk1("lk_next_write", mem_write_o, 1'b0);
    chk64("lk_next_addr", 64'(mem_address_o), 64'h031);
    chk1("lk_next_wr_wait", wr_waitrequest_o, 1'b1);
    tick();
    rd_read_i = 1'b0; mem_readdatavalid_i = 1'b1;
    #1;
    chk1("lk_tail_write", mem_write_o, 1'b1);
    tick();
    idle_in();

    // Pending-read cap blocks reads but not writes
    for (int i = 0; i < 4; i++) begin
      tick();
      rd_read_i = 1'b1; rd_address_i = AW'('h50 + i);
      #1;
      chk1("cap_fill_read", mem_read_o, 1'b1);
    end
    tick();
    rd_address_i = 10'h054;
    wr_write_i = 1'b1; wr_address_i = 10'h060;
    #1;
    chk64("cap_pend4", 64'(pending_rd_o), 64'd4);
    chk1("cap_rd_wait", rd_waitrequest_o, 1'b1);
    chk1("cap_read_blocked", mem_read_o, 1'b0);
    chk1("cap_write", mem_write_o, 1'b1);
    chk1("cap_wr_wait", wr_waitrequest_o, 1'b0);
    tick();
    wr_write_i = 1'b0; mem_readdatavalid_i = 1'b1;
    #1;
    chk1("cap_still_blocked", mem_read_o, 1'b0);
    chk1("cap_still_wait", rd_waitrequest_o, 1'b1);
    tick();
    mem_readdatavalid_i = 1'b0;
    #1;
    chk64("cap_pend3", 64'(pending_rd_o), 64'd3);
    chk1("cap_read_go", mem_read_o, 1'b1);
    chk64("cap_read_addr", 64'(mem_address_o), 64'h054);
    tick();
    rd_read_i = 1'b0;
    #1;
    chk64("cap_pend_refill", 64'(pending_rd_o), 64'd4);
    repeat (4) begin
      tick();
      mem_readdatavalid_i = 1'b1;
    end
    tick();
    mem_readdatavalid_i = 1'b0;
    #1;
    chk64("cap_drained", 64'(pending_rd_o), 64'd0);

    // Async reset during a read stall with two reads in flight
    tick();
    rd_read_i = 1'b1; rd_address_i = 10'h070;
    tick();
    rd_address_i = 10'h071;
    tick();
    rd_address_i = 10'h072; mem_waitrequest_i = 1'b1;
    #1;
    chk1("rl_stall_read", mem_read_o, 1'b1);
    tick();
    wr_write_i = 1'b1; wr_address_i = 10'h080;
    #1;
    chk64("rl_pend2", 64'(pending_rd_o), 64'd2);
    chk1("rl_lock_read", mem_read_o, 1'b1);
    chk1("rl_lock_wr_wait", wr_waitrequest_o, 1'b1);
    rst_n_i = 1'b0;
    #1;
    chk1("rl_rst_read", mem_read_o, 1'b0);
    chk1("rl_rst_write", mem_write_o, 1'b0);
    chk64("rl_rst_pend", 64'(pending_rd_o), 64'd0);
    tick();
    tick();
    mem_waitrequest_i = 1'b0;
    rst_n_i = 1'b1;
    #1;
    chk1("rl_tie_read", mem_read_o, 1'b1);
    chk1("rl_tie_write", mem_write_o, 1'b0);
    tick();
    rd_read_i = 1'b0;
    #1;
    chk1("rl_then_write", mem_write_o, 1'b1);
    tick();
    idle_in();
    mem_readdatavalid_i = 1'b1;
    tick();
    mem_readdatavalid_i = 1'b0;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!(rd_read_i && !m_rd_acc) || ($urandom_range(0, 99) < 3)) begin
        rd_read_i    = ($urandom_range(0, 99) < 60);
        rd_address_i = AW'($urandom);
      end
      if (!(wr_write_i && !m_wr_acc) || ($urandom_range(0, 99) < 3)) begin
        wr_write_i      = ($urandom_range(0, 99) < 60);
        wr_address_i    = AW'($urandom);
        wr_writedata_i  = {$urandom, $urandom};
        wr_byteenable_i = BC'($urandom);
      end
      mem_waitrequest_i   = ($urandom_range(0, 99) < 30);
      mem_readdatavalid_i = (m_pend > 0) && ($urandom_range(0, 99) < 40);
      mem_readdata_i      = {$urandom, $urandom};
    end

    // Quiesce and drain outstanding responses
    tick();
    idle_in();
    for (int d = 0; d < 20 && m_pend > 0; d++) begin
      mem_readdatavalid_i = 1'b1;
      tick();
    end
    mem_readdatavalid_i = 1'b0;
    tick();
    #1;
    chk64("final_pend", 64'(pending_rd_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
